// File: rtl/game_sprite_bounce_ctrl_pkg.sv
// Shared types and boundary defaults for the sprite bounce controller.
//   state_e      : controller state encoding
//   *_DEF        : default coordinate widths and screen boundaries
package game_sprite_bounce_ctrl_pkg;

  localparam int unsigned X_WIDTH_DEF  = 10;
  localparam int unsigned Y_WIDTH_DEF  = 10;
  localparam int unsigned DX_WIDTH_DEF = 2;
  localparam int unsigned DY_WIDTH_DEF = 2;
  localparam int unsigned X_MIN_DEF    = 0;
  localparam int unsigned X_MAX_DEF    = 639;
  localparam int unsigned Y_MIN_DEF    = 0;
  localparam int unsigned Y_MAX_DEF    = 479;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_FLY    = 3'd2,
    ST_BOUNCE = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

endpackage

// File: rtl/game_speed_reflect.sv
// Saturating two's-complement negate used to reflect a sprite speed.
//   spd_i  : speed in (two's complement)
//   refl_c : -spd_i, with the most negative value mapped to the most positive
module game_speed_reflect #(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] spd_i,
  output logic [WIDTH-1:0] refl_c
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  // Plain negate of MOST_NEG overflows back to itself, so saturate it.
  always_comb begin
    refl_c = (~spd_i) + ONE;
    if (spd_i == MOST_NEG) begin
      refl_c = MOST_POS;
    end
  end

endmodule

// File: rtl/game_sprite_bounce_ctrl.sv
// Sprite bounce controller: launches a sprite, watches its position feedback,
// issues clamp/reflect writes at screen edges and freezes it after
// MAX_BOUNCES bounces or on stop.
//   clk, reset                  : clock, asynchronous active-high reset
//   start, stop                 : launch/relaunch and freeze pulses
//   start_x/y/dx/dy             : launch position and speed
//   sprite_x/y                  : current position from sprite control
//   sprite_write, sprite_write_*: one-cycle write strobe and its payload
//   active                      : high in LAUNCH/FLY/BOUNCE
//   done                        : one-cycle pulse on entry to HALT
//   bounce_count                : bounces since last launch
module game_sprite_bounce_ctrl
  import game_sprite_bounce_ctrl_pkg::*;
#(
  parameter int unsigned X_WIDTH     = X_WIDTH_DEF,
  parameter int unsigned Y_WIDTH     = Y_WIDTH_DEF,
  parameter int unsigned DX_WIDTH    = DX_WIDTH_DEF,
  parameter int unsigned DY_WIDTH    = DY_WIDTH_DEF,
  parameter int unsigned X_MIN       = X_MIN_DEF,
  parameter int unsigned X_MAX       = X_MAX_DEF,
  parameter int unsigned Y_MIN       = Y_MIN_DEF,
  parameter int unsigned Y_MAX       = Y_MAX_DEF,
  parameter int unsigned MAX_BOUNCES = 8,
  parameter int unsigned CNT_WIDTH   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [X_WIDTH-1:0]  start_x,
  input  logic [Y_WIDTH-1:0]  start_y,
  input  logic [DX_WIDTH-1:0] start_dx,
  input  logic [DY_WIDTH-1:0] start_dy,
  input  logic [X_WIDTH-1:0]  sprite_x,
  input  logic [Y_WIDTH-1:0]  sprite_y,
  output logic                sprite_write,
  output logic [X_WIDTH-1:0]  sprite_write_x,
  output logic [Y_WIDTH-1:0]  sprite_write_y,
  output logic [DX_WIDTH-1:0] sprite_write_dx,
  output logic [DY_WIDTH-1:0] sprite_write_dy,
  output logic                active,
  output logic                done,
  output logic [CNT_WIDTH-1:0] bounce_count
);

  localparam logic [X_WIDTH-1:0]   XMIN = X_WIDTH'(X_MIN);
  localparam logic [X_WIDTH-1:0]   XMAX = X_WIDTH'(X_MAX);
  localparam logic [Y_WIDTH-1:0]   YMIN = Y_WIDTH'(Y_MIN);
  localparam logic [Y_WIDTH-1:0]   YMAX = Y_WIDTH'(Y_MAX);
  localparam logic [CNT_WIDTH-1:0] CMAX = CNT_WIDTH'(MAX_BOUNCES);

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [X_WIDTH-1:0]  wr_x_q, wr_x_d;
  logic [Y_WIDTH-1:0]  wr_y_q, wr_y_d;
  logic [DX_WIDTH-1:0] wr_dx_q, wr_dx_d;
  logic [DY_WIDTH-1:0] wr_dy_q, wr_dy_d;
  logic [DX_WIDTH-1:0] dx_q, dx_d;
  logic [DY_WIDTH-1:0] dy_q, dy_d;
  logic                active_q, active_d;
  logic                done_q, done_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [DX_WIDTH-1:0] dx_refl;
  logic [DY_WIDTH-1:0] dy_refl;
  logic dx_neg, dx_pos, dy_neg, dy_pos;
  logic hit_l, hit_r, hit_t, hit_b, hit_x, hit_y;
  logic go_halt;

  game_speed_reflect #(.WIDTH(DX_WIDTH)) u_refl_dx (
    .spd_i  (dx_q),
    .refl_c (dx_refl)
  );

  game_speed_reflect #(.WIDTH(DY_WIDTH)) u_refl_dy (
    .spd_i  (dy_q),
    .refl_c (dy_refl)
  );

  // Edge detection; a coordinate above MAX while moving negative has wrapped below zero.
  always_comb begin
    dx_neg = dx_q[DX_WIDTH-1];
    dx_pos = !dx_q[DX_WIDTH-1] && (dx_q != '0);
    dy_neg = dy_q[DY_WIDTH-1];
    dy_pos = !dy_q[DY_WIDTH-1] && (dy_q != '0);
    hit_l  = dx_neg && ((sprite_x <= XMIN) || (sprite_x > XMAX));
    hit_r  = dx_pos && (sprite_x >= XMAX);
    hit_t  = dy_neg && ((sprite_y <= YMIN) || (sprite_y > YMAX));
    hit_b  = dy_pos && (sprite_y >= YMAX);
    hit_x  = hit_l || hit_r;
    hit_y  = hit_t || hit_b;
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      write_q  <= 1'b0;
      wr_x_q   <= '0;
      wr_y_q   <= '0;
      wr_dx_q  <= '0;
      wr_dy_q  <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      wr_x_q   <= wr_x_d;
      wr_y_q   <= wr_y_d;
      wr_dx_q  <= wr_dx_d;
      wr_dy_q  <= wr_dy_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      active_q <= active_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state and next outputs; the write payload is computed on the transition
  // into the writing state so it appears together with the strobe.
  always_comb begin
    state_d  = state_q;
    write_d  = 1'b0;
    wr_x_d   = wr_x_q;
    wr_y_d   = wr_y_q;
    wr_dx_d  = wr_dx_q;
    wr_dy_d  = wr_dy_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    go_halt  = 1'b0;

    if (start) begin
      state_d = ST_LAUNCH;
      write_d = 1'b1;
      wr_x_d  = start_x;
      wr_y_d  = start_y;
      wr_dx_d = start_dx;
      wr_dy_d = start_dy;
      dx_d    = start_dx;
      dy_d    = start_dy;
      cnt_d   = '0;
    end else if (stop && (state_q == ST_LAUNCH || state_q == ST_FLY ||
                          state_q == ST_BOUNCE)) begin
      go_halt = 1'b1;
    end else begin
      unique case (state_q)
        ST_LAUNCH: state_d = ST_FLY;
        ST_FLY: begin
          if (hit_x || hit_y) begin
            state_d = ST_BOUNCE;
            write_d = 1'b1;
            wr_x_d  = hit_l ? XMIN : (hit_r ? XMAX : sprite_x);
            wr_y_d  = hit_t ? YMIN : (hit_b ? YMAX : sprite_y);
            wr_dx_d = hit_x ? dx_refl : dx_q;
            wr_dy_d = hit_y ? dy_refl : dy_q;
            dx_d    = wr_dx_d;
            dy_d    = wr_dy_d;
            if (cnt_q < CMAX) begin
              cnt_d = CNT_WIDTH'(cnt_q + 1'b1);
            end
          end
        end
        ST_BOUNCE: begin
          if (cnt_q == CMAX) begin
            go_halt = 1'b1;
          end else begin
            state_d = ST_FLY;
          end
        end
        ST_IDLE, ST_HALT: state_d = state_q;
        default: state_d = ST_IDLE;
      endcase
    end

    // Freeze: write the live position with zero speed.
    if (go_halt) begin
      state_d = ST_HALT;
      write_d = 1'b1;
      wr_x_d  = sprite_x;
      wr_y_d  = sprite_y;
      wr_dx_d = '0;
      wr_dy_d = '0;
      dx_d    = '0;
      dy_d    = '0;
      done_d  = 1'b1;
    end

    active_d = (state_d == ST_LAUNCH) || (state_d == ST_FLY) ||
               (state_d == ST_BOUNCE);
  end

  assign sprite_write    = write_q;
  assign sprite_write_x  = wr_x_q;
  assign sprite_write_y  = wr_y_q;
  assign sprite_write_dx = wr_dx_q;
  assign sprite_write_dy = wr_dy_q;
  assign active          = active_q;
  assign done            = done_q;
  assign bounce_count    = cnt_q;

endmodule

// File: tb/tb_game_sprite_bounce_ctrl.sv
// Directed bench for game_sprite_bounce_ctrl (MAX_BOUNCES = 2).
module tb_game_sprite_bounce_ctrl;

  logic       clk;
  logic       reset;
  logic       start, stop;
  logic [9:0] start_x, start_y;
  logic [1:0] start_dx, start_dy;
  logic [9:0] sprite_x, sprite_y;
  logic       sprite_write;
  logic [9:0] sprite_write_x, sprite_write_y;
  logic [1:0] sprite_write_dx, sprite_write_dy;
  logic       active, done;
  logic [3:0] bounce_count;

  int n_cmp = 0;
  int n_mis = 0;

  game_sprite_bounce_ctrl #(.MAX_BOUNCES(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .stop            (stop),
    .start_x         (start_x),
    .start_y         (start_y),
    .start_dx        (start_dx),
    .start_dy        (start_dy),
    .sprite_x        (sprite_x),
    .sprite_y        (sprite_y),
    .sprite_write    (sprite_write),
    .sprite_write_x  (sprite_write_x),
    .sprite_write_y  (sprite_write_y),
    .sprite_write_dx (sprite_write_dx),
    .sprite_write_dy (sprite_write_dy),
    .active          (active),
    .done            (done),
    .bounce_count    (bounce_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st, sp;
    logic [9:0] sx, sy;
    logic [1:0] sdx, sdy;
    logic [9:0] px, py;
    logic       e_wr;
    logic [9:0] e_x, e_y;
    logic [1:0] e_dx, e_dy;
    logic       e_act, e_done;
    logic [3:0] e_cnt;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mk(logic st, logic sp, int sx, int sy, int sdx, int sdy,
                              int px, int py, logic e_wr, int e_x, int e_y,
                              int e_dx, int e_dy, logic e_act, logic e_done, int e_cnt);
    vec_t v;
    v.st = st; v.sp = sp;
    v.sx = 10'(sx); v.sy = 10'(sy); v.sdx = 2'(sdx); v.sdy = 2'(sdy);
    v.px = 10'(px); v.py = 10'(py);
    v.e_wr = e_wr; v.e_x = 10'(e_x); v.e_y = 10'(e_y);
    v.e_dx = 2'(e_dx); v.e_dy = 2'(e_dy);
    v.e_act = e_act; v.e_done = e_done; v.e_cnt = 4'(e_cnt);
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input vec_t v);
    chk("sprite_write", idx, 32'(sprite_write), 32'(v.e_wr));
    chk("write_x", idx, 32'(sprite_write_x), 32'(v.e_x));
    chk("write_y", idx, 32'(sprite_write_y), 32'(v.e_y));
    chk("write_dx", idx, 32'(sprite_write_dx), 32'(v.e_dx));
    chk("write_dy", idx, 32'(sprite_write_dy), 32'(v.e_dy));
    chk("active", idx, 32'(active), 32'(v.e_act));
    chk("done", idx, 32'(done), 32'(v.e_done));
    chk("bounce_count", idx, 32'(bounce_count), 32'(v.e_cnt));
  endtask

  initial begin
    // -1 = 3, -2 = 2 in 2-bit speed fields
    vecs[0]  = mk(1,0,100,100,1,1, 100,100, 1,100,100,1,1, 1,0,0); // launch
    vecs[1]  = mk(0,0,0,0,0,0,     100,100, 0,100,100,1,1, 1,0,0);
    vecs[2]  = mk(0,0,0,0,0,0,     639,200, 1,639,200,3,1, 1,0,1); // right wall
    vecs[3]  = mk(0,0,0,0,0,0,     639,200, 0,639,200,3,1, 1,0,1);
    vecs[4]  = mk(0,0,0,0,0,0,     639,200, 0,639,200,3,1, 1,0,1); // no retrigger
    vecs[5]  = mk(1,0,50,50,2,0,   50,50,   1,50,50,2,0,   1,0,0);
    vecs[6]  = mk(0,0,0,0,0,0,     50,50,   0,50,50,2,0,   1,0,0);
    vecs[7]  = mk(0,0,0,0,0,0,     1023,300,1,0,300,1,0,   1,0,1); // left wrap
    vecs[8]  = mk(0,0,0,0,0,0,     1023,300,0,0,300,1,0,   1,0,1); // ignored in BOUNCE
    vecs[9]  = mk(1,0,600,400,1,1, 600,400, 1,600,400,1,1, 1,0,0);
    vecs[10] = mk(0,0,0,0,0,0,     600,400, 0,600,400,1,1, 1,0,0);
    vecs[11] = mk(0,0,0,0,0,0,     639,479, 1,639,479,3,3, 1,0,1); // corner
    vecs[12] = mk(0,0,0,0,0,0,     639,479, 0,639,479,3,3, 1,0,1);
    vecs[13] = mk(0,0,0,0,0,0,     0,300,   1,0,300,1,3,   1,0,2); // second bounce
    vecs[14] = mk(0,0,0,0,0,0,     5,301,   1,5,301,0,0,   0,1,2); // auto halt
    vecs[15] = mk(0,0,0,0,0,0,     5,301,   0,5,301,0,0,   0,0,2);
    vecs[16] = mk(0,1,0,0,0,0,     6,302,   0,5,301,0,0,   0,0,2); // stop in HALT
    vecs[17] = mk(1,0,200,200,1,3, 200,200, 1,200,200,1,3, 1,0,0);
    vecs[18] = mk(0,0,0,0,0,0,     200,200, 0,200,200,1,3, 1,0,0);
    vecs[19] = mk(0,0,0,0,0,0,     639,190, 1,639,190,3,3, 1,0,1);
    vecs[20] = mk(0,0,0,0,0,0,     639,190, 0,639,190,3,3, 1,0,1);
    vecs[21] = mk(1,1,20,30,3,1,   639,190, 1,20,30,3,1,   1,0,0); // start beats stop
    vecs[22] = mk(0,0,0,0,0,0,     20,30,   0,20,30,3,1,   1,0,0);
    vecs[23] = mk(0,1,0,0,0,0,     77,88,   1,77,88,0,0,   0,1,0); // stop in FLY

    start = 0; stop = 0; start_x = 0; start_y = 0; start_dx = 0; start_dy = 0;
    sprite_x = 0; sprite_y = 0;
    reset = 1'b1;
    #1;
    chk("reset_write", -1, 32'(sprite_write), 32'd0);
    chk("reset_active", -1, 32'(active), 32'd0);
    chk("reset_done", -1, 32'(done), 32'd0);
    chk("reset_count", -1, 32'(bounce_count), 32'd0);
    chk("reset_wx", -1, 32'(sprite_write_x), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      start = vecs[i].st; stop = vecs[i].sp;
      start_x = vecs[i].sx; start_y = vecs[i].sy;
      start_dx = vecs[i].sdx; start_dy = vecs[i].sdy;
      sprite_x = vecs[i].px; sprite_y = vecs[i].py;
      @(posedge clk);
      #1;
      chk_all(i, vecs[i]);
    end

    // Reset asserted while a launch write is on the port.
    @(negedge clk);
    start = 1; stop = 0; start_x = 10'd100; start_y = 10'd100;
    start_dx = 2'd1; start_dy = 2'd1;
    @(posedge clk);
    #1;
    chk("pre_reset_write", 100, 32'(sprite_write), 32'd1);
    start = 0;
    #1 reset = 1'b1;
    #1;
    chk("async_write", 101, 32'(sprite_write), 32'd0);
    chk("async_wx", 101, 32'(sprite_write_x), 32'd0);
    chk("async_wdx", 101, 32'(sprite_write_dx), 32'd0);
    chk("async_active", 101, 32'(active), 32'd0);
    chk("async_count", 101, 32'(bounce_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_write", 102, 32'(sprite_write), 32'd0);
    chk("idle_active", 102, 32'(active), 32'd0);

    // stop in IDLE is ignored.
    @(negedge clk);
    stop = 1;
    @(posedge clk);
    #1;
    chk("idle_stop_write", 103, 32'(sprite_write), 32'd0);
    chk("idle_stop_done", 103, 32'(done), 32'd0);
    chk("idle_stop_active", 103, 32'(active), 32'd0);
    @(negedge clk);
    stop = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
